// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed load/store front end for a word-wide data memory
// Sub-word stores use read-modify-write because the memory has only a full-word write enable.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state;
  logic        write_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [31:0] rdata_q;
  logic        err_q;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic m;
    case (size)
      2'b00:   m = 1'b0;
      2'b01:   m = off[0];
      default: m = (off != 2'b00);
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'b0, b};
      2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane(s) of the captured word.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wdata,
                                        input logic [1:0] size, input logic [1:0] off);
    logic [31:0] m;
    m = word;
    case (size)
      2'b00: m[{off, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (off[1]) m[31:16] = wdata[15:0];
        else        m[15:0]  = wdata[15:0];
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESP);
  assign resp_err       = err_q;
  assign resp_rdata     = rdata_q;
  assign mem_we         = (state == WRITE);
  assign mem_address    = {2'b00, addr_q[31:2]};
  assign mem_write_data = mem_we ? merge(data_q, wdata_q, size_q, addr_q[1:0]) : 32'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= 32'b0;
      wdata_q  <= 32'b0;
      data_q   <= 32'b0;
      rdata_q  <= 32'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= 32'b0;
            err_q    <= misaligned(req_size, req_addr[1:0]);
            if (misaligned(req_size, req_addr[1:0]))
              state <= RESP;
            else if (!req_write || req_size == 2'b00 || req_size == 2'b01)
              state <= READ;
            else
              state <= WRITE;
          end
        end
        READ: begin
          data_q <= mem_read_data;
          if (!write_q) begin
            rdata_q <= extract(mem_read_data, size_q, addr_q[1:0], signed_q);
            state   <= RESP;
          end else begin
            state <= WRITE;
          end
        end
        WRITE: state <= RESP;
        RESP: begin
          err_q   <= 1'b0;
          rdata_q <= 32'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
